// File: rtl/stopwatch_tx_if.sv
// Byte-stream link from the stopwatch formatter to the UART transmitter.
// Handshake: a byte moves on a rising clk edge where tx_valid=1 and tx_ready=1;
// while tx_valid=1 and tx_ready=0 the master holds tx_data and tx_valid stable,
// and tx_ready is ignored while tx_valid=0.
interface stopwatch_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/stopwatch_tx_formatter.sv
// stopwatch_tx_formatter: snapshots the four stopwatch BCD digits on a trigger
// and streams them as ASCII "SS.HH" plus CR LF (or LF only) over the tx link.
// Optional macro LEADING_ZERO_BLANK_EN: a zero tens-of-seconds digit is sent
// as a space instead of '0'.
// dbg_send mirrors the FSM state (0 = IDLE, 1 = SEND).
module stopwatch_tx_formatter #(
  parameter logic [7:0] SEP_CHAR = 8'h2E,
  parameter bit         SEND_CR  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trigger,
  input  logic [3:0]    digit0,
  input  logic [3:0]    digit1,
  input  logic [3:0]    digit2,
  input  logic [3:0]    digit3,
  stopwatch_tx_if.master tx,
  output logic          busy,
  output logic          done,
  output logic          dropped,
  output logic          dbg_send
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index of the LF byte, which is always the last one of the frame.
  localparam logic [2:0] LAST_IDX = SEND_CR ? 3'd6 : 3'd5;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] snap_q, snap_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dropped_q, dropped_d;

  // Out-of-range BCD values are flagged with '?' rather than wrapped.
  function automatic logic [7:0] enc_digit(input logic [3:0] v);
    logic [7:0] b;
    if (v <= 4'd9) b = 8'h30 + {4'h0, v};
    else           b = 8'h3F;
    return b;
  endfunction

  // Byte at a given frame position, taken from the latched snapshot.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] snap);
    logic [7:0] b;
    b = 8'h0A;
    case (idx)
      3'd0: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (snap[15:12] == 4'd0) b = 8'h20;
        else                     b = enc_digit(snap[15:12]);
`else
        b = enc_digit(snap[15:12]);
`endif
      end
      3'd1:    b = enc_digit(snap[11:8]);
      3'd2:    b = SEP_CHAR;
      3'd3:    b = enc_digit(snap[7:4]);
      3'd4:    b = enc_digit(snap[3:0]);
      3'd5:    b = SEND_CR ? 8'h0D : 8'h0A;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // Next-state and next-output logic; done/dropped default low so they pulse.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          snap_d  = {digit3, digit2, digit1, digit0};
          state_d = SEND;
          idx_d   = 3'd0;
          data_d  = frame_byte(3'd0, {digit3, digit2, digit1, digit0});
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        // A frame is never queued behind the current one.
        if (trigger) dropped_d = 1'b1;
        if (valid_q && tx.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            // Final LF accepted: tx_data keeps the LF byte.
            state_d = IDLE;
            idx_d   = 3'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = frame_byte(idx_q + 3'd1, snap_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      snap_q    <= 16'h0000;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dropped     = dropped_q;
  assign dbg_send    = (state_q == SEND);

endmodule
